// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer
//   On-chip trace capture for the top_mips core. NUM_CH channels of DATA_W bits
//   are sampled on every cap_en cycle into a DEPTH-entry circular buffer. A
//   masked PC match on ch0 starts a post-trigger countdown. When the countdown
//   ends, capture stops and the stored window can be read out oldest-first.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   When it is defined, a free-running 32-bit cycle counter is stored with each
//   sample. The stored value is returned on rd_ts with the same timing as rd_data.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   arm                   start a new capture (IDLE/DONE only)
//   cap_en, cap_data      sample qualifier and packed channels (ch0 in LSBs)
//   trig_value/trig_mask  ch0 compare value and mask (1 = bit compared)
//   post_count            samples stored after the trigger sample
//   rd_en, rd_idx         read request (DONE only), index 0 = oldest sample
//   rd_valid, rd_data     read result, one cycle after rd_en
//   state                 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   triggered, wrapped    sticky trigger flag, buffer-overwrote-oldest flag
//   count                 stored samples, saturates at DEPTH
//   rd_ts                 (TRACE_TIMESTAMP_EN only) timestamp of the read sample
module mips_trace_buffer #(
   parameter  int DATA_W = 32,
   parameter  int NUM_CH = 5,
   parameter  int DEPTH  = 64,
   localparam int AW     = $clog2(DEPTH),
   localparam int SW     = NUM_CH * DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              cap_en,
   input  logic [SW-1:0]     cap_data,
   input  logic [DATA_W-1:0] trig_value,
   input  logic [DATA_W-1:0] trig_mask,
   input  logic [AW-1:0]     post_count,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic [SW-1:0]     rd_data,
   output logic [1:0]        state,
   output logic              triggered,
   output logic              wrapped,
   output logic [AW:0]       count
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [31:0]       rd_ts
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_POST  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] ONE_PC   = {{(AW - 1){1'b0}}, 1'b1};

   logic [1:0]        state_r;
   logic [AW-1:0]     wr_ptr_r;
   logic [AW:0]       count_r;
   logic              triggered_r;
   logic              wrapped_r;
   logic [AW-1:0]     post_cnt_r;
   logic              rd_valid_r;
   logic [SW-1:0]     rd_data_r;
   logic [SW-1:0]     mem [DEPTH];

   logic              wr_fire_s;
   logic              arm_ok_s;
   logic              trig_hit_s;
   logic              rd_fire_s;
   logic              rd_in_range_s;
   logic [AW-1:0]     rd_addr_s;

   // Decode write, arm, trigger and read qualifiers from the current state.
   always_comb begin
      wr_fire_s     = cap_en && ((state_r == ST_ARMED) || (state_r == ST_POST));
      arm_ok_s      = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));
      trig_hit_s    = cap_en && (state_r == ST_ARMED) &&
                      (((cap_data[DATA_W-1:0] ^ trig_value) & trig_mask) == {DATA_W{1'b0}});
      rd_fire_s     = rd_en && (state_r == ST_DONE);
      rd_in_range_s = ({1'b0, rd_idx} < count_r);
      // Once the buffer has wrapped, the oldest entry is the next one to be overwritten.
      if (wrapped_r) begin
         rd_addr_s = wr_ptr_r + rd_idx;
      end else begin
         rd_addr_s = rd_idx;
      end
   end

   // Sample storage. This block has no reset, so the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_fire_s && !reset) begin
         mem[wr_ptr_r] <= cap_data;
      end
   end

   // Capture state machine: arm, trigger detection and post-trigger countdown.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         triggered_r <= 1'b0;
         post_cnt_r  <= {AW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (arm_ok_s) begin
                  state_r     <= ST_ARMED;
                  triggered_r <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (trig_hit_s) begin
                  triggered_r <= 1'b1;
                  post_cnt_r  <= post_count;
                  state_r     <= (post_count == {AW{1'b0}}) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               if (cap_en) begin
                  post_cnt_r <= post_cnt_r - ONE_PC;
                  if (post_cnt_r == ONE_PC) begin
                     state_r <= ST_DONE;
                  end
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Write pointer, saturating sample count and wrap flag.
   always_ff @(posedge clk) begin
      if (reset || arm_ok_s) begin
         wr_ptr_r  <= {AW{1'b0}};
         count_r   <= {(AW + 1){1'b0}};
         wrapped_r <= 1'b0;
      end else if (wr_fire_s) begin
         wr_ptr_r <= wr_ptr_r + ONE_PC;
         if (count_r == FULL_CNT) begin
            wrapped_r <= 1'b1;
         end else begin
            count_r <= count_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Registered readout. Indices beyond the stored window return zeros.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= {SW{1'b0}};
      end else if (rd_fire_s) begin
         rd_valid_r <= 1'b1;
         rd_data_r  <= rd_in_range_s ? mem[rd_addr_s] : {SW{1'b0}};
      end else begin
         rd_valid_r <= 1'b0;
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts_cnt_r;
   logic [31:0] rd_ts_r;
   logic [31:0] ts_mem [DEPTH];

   // Free-running cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_cnt_r <= 32'd0;
      end else begin
         ts_cnt_r <= ts_cnt_r + 32'd1;
      end
   end

   // Timestamp storage, written alongside the sample RAM.
   always_ff @(posedge clk) begin
      if (wr_fire_s && !reset) begin
         ts_mem[wr_ptr_r] <= ts_cnt_r;
      end
   end

   // Timestamp readout, with the same timing as rd_data.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ts_r <= 32'd0;
      end else if (rd_fire_s) begin
         rd_ts_r <= rd_in_range_s ? ts_mem[rd_addr_s] : 32'd0;
      end else begin
         rd_ts_r <= rd_ts_r;
      end
   end

   assign rd_ts = rd_ts_r;
`endif

   assign state     = state_r;
   assign triggered = triggered_r;
   assign wrapped   = wrapped_r;
   assign count     = count_r;
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed testbench for mips_trace_buffer (DATA_W=32, NUM_CH=5, DEPTH=64).
// Inputs change 1 time unit after each rising edge, and outputs are sampled there too.
module tb_mips_trace_buffer;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         arm = 1'b0;
   logic         cap_en = 1'b0;
   logic [159:0] cap_data = '0;
   logic [31:0]  trig_value = '0;
   logic [31:0]  trig_mask = '0;
   logic [5:0]   post_count = '0;
   logic         rd_en = 1'b0;
   logic [5:0]   rd_idx = '0;
   logic         rd_valid;
   logic [159:0] rd_data;
   logic [1:0]   state;
   logic         triggered;
   logic         wrapped;
   logic [6:0]   count;
`ifdef TRACE_TIMESTAMP_EN
   logic [31:0]  rd_ts;
   logic [31:0]  ts_seen [8];
`endif

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   mips_trace_buffer dut (
      .clk(clk), .reset(reset), .arm(arm), .cap_en(cap_en), .cap_data(cap_data),
      .trig_value(trig_value), .trig_mask(trig_mask), .post_count(post_count),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
      .state(state), .triggered(triggered), .wrapped(wrapped), .count(count)
`ifdef TRACE_TIMESTAMP_EN
      , .rd_ts(rd_ts)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [159:0] mk(input logic [31:0] c0);
      return {c0 ^ 32'hFFFF_0000, c0 + 32'd3, c0 ^ 32'h0000_FFFF, c0 + 32'd1, c0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cap(input logic [31:0] c0, input logic en);
      cap_data = mk(c0);
      cap_en   = en;
      tick();
      cap_en   = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [5:0] idx, input logic [159:0] exp);
      rd_en  = 1'b1;
      rd_idx = idx;
      tick();
      rd_en  = 1'b0;
      check({tag, "_valid"}, 160'(rd_valid), 160'd1);
      check({tag, "_data"}, rd_data, exp);
   endtask

   initial begin
      // ---- Test 1: basic capture, trigger on 0x105, post_count 2 ----
      tick(); tick();
      reset = 1'b0;
      check("rst_state", 160'(state), 160'd0);
      check("rst_count", 160'(count), 160'd0);
      check("rst_trig", 160'(triggered), 160'd0);
      check("rst_wrap", 160'(wrapped), 160'd0);
      check("rst_rdv", 160'(rd_valid), 160'd0);
      check("rst_rdd", rd_data, 160'd0);
      trig_value = 32'h0000_0105;
      trig_mask  = 32'hFFFF_FFFF;
      post_count = 6'd2;
      do_arm();
      check("t1_armed", 160'(state), 160'd1);
      for (int i = 0; i < 6; i++) cap(32'h100 + 32'(i), 1'b1);
      check("t1_post", 160'(state), 160'd2);
      check("t1_trig", 160'(triggered), 160'd1);
      for (int i = 6; i < 10; i++) cap(32'h100 + 32'(i), 1'b1);
      check("t1_done", 160'(state), 160'd3);
      check("t1_count", 160'(count), 160'd8);
      check("t1_wrap", 160'(wrapped), 160'd0);
      for (int i = 0; i < 8; i++) rd("t1_rd", 6'(i), mk(32'h100 + 32'(i)));
      tick();
      check("t1_rdv_drop", 160'(rd_valid), 160'd0);

      // ---- Test 2: wrap-around with 100 pre-trigger samples ----
      trig_value = 32'h1000_0064;
      post_count = 6'd10;
      do_arm();
      check("t2_trig_clr", 160'(triggered), 160'd0);
      check("t2_count_clr", 160'(count), 160'd0);
      for (int s = 0; s < 116; s++) cap(32'h1000_0000 + 32'(s), 1'b1);
      check("t2_done", 160'(state), 160'd3);
      check("t2_count", 160'(count), 160'd64);
      check("t2_wrap", 160'(wrapped), 160'd1);
      rd("t2_rd0", 6'd0, mk(32'h1000_0000 + 32'd47));
      rd("t2_rd53", 6'd53, mk(32'h1000_0000 + 32'd100));
      rd("t2_rd63", 6'd63, mk(32'h1000_0000 + 32'd110));

      // ---- Test 3: stalls during POST, disabled match ignored, arm ignored ----
      trig_value = 32'h2000_0003;
      post_count = 6'd3;
      do_arm();
      cap(32'h2000_0003, 1'b0);
      check("t3_nomatch_state", 160'(state), 160'd1);
      check("t3_nomatch_count", 160'(count), 160'd0);
      cap(32'h2000_0001, 1'b1);
      cap(32'h2000_0002, 1'b1);
      cap(32'h2000_0003, 1'b1);
      check("t3_post", 160'(state), 160'd2);
      cap(32'h2000_0004, 1'b1);
      arm = 1'b1;
      cap(32'h2000_0005, 1'b0);
      arm = 1'b0;
      check("t3_arm_ignored", 160'(state), 160'd2);
      cap(32'h2000_0006, 1'b1);
      cap(32'h2000_0007, 1'b0);
      check("t3_still_post", 160'(state), 160'd2);
      cap(32'h2000_0008, 1'b1);
      check("t3_done", 160'(state), 160'd3);
      check("t3_count", 160'(count), 160'd6);
      rd("t3_rd0", 6'd0, mk(32'h2000_0001));
      rd("t3_rd3", 6'd3, mk(32'h2000_0004));
      rd("t3_rd4", 6'd4, mk(32'h2000_0006));
      rd("t3_rd5", 6'd5, mk(32'h2000_0008));

      // ---- Test 4: mask 0, post_count 0, out-of-range read ----
      trig_mask  = 32'h0000_0000;
      post_count = 6'd0;
      do_arm();
      cap(32'h3000_0000, 1'b0);
      check("t4_armed", 160'(state), 160'd1);
      cap(32'h3000_0042, 1'b1);
      check("t4_done", 160'(state), 160'd3);
      check("t4_count", 160'(count), 160'd1);
      rd("t4_rd5", 6'd5, 160'd0);
      rd("t4_rd0", 6'd0, mk(32'h3000_0042));

      // ---- Test 5: reset in POST, then normal re-capture ----
      trig_value = 32'h4000_0001;
      trig_mask  = 32'hFFFF_FFFF;
      post_count = 6'd5;
      do_arm();
      cap(32'h4000_0000, 1'b1);
      cap(32'h4000_0001, 1'b1);
      cap(32'h4000_0002, 1'b1);
      check("t5_post", 160'(state), 160'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_state", 160'(state), 160'd0);
      check("t5_count", 160'(count), 160'd0);
      check("t5_trig", 160'(triggered), 160'd0);
      check("t5_rdd_rst", rd_data, 160'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t5_idle_rdv", 160'(rd_valid), 160'd0);
      trig_value = 32'h5000_0001;
      post_count = 6'd1;
      do_arm();
      cap(32'h5000_0000, 1'b1);
      cap(32'h5000_0001, 1'b1);
      cap(32'h5000_0002, 1'b1);
      check("t5_done", 160'(state), 160'd3);
      check("t5_count2", 160'(count), 160'd3);
      rd("t5_rd2", 6'd2, mk(32'h5000_0002));

`ifdef TRACE_TIMESTAMP_EN
      // ---- Test 6: back-to-back samples give consecutive timestamps ----
      trig_mask  = 32'h0000_0000;
      post_count = 6'd7;
      do_arm();
      for (int i = 0; i < 8; i++) cap(32'h6000_0000 + 32'(i), 1'b1);
      check("t6_done", 160'(state), 160'd3);
      for (int i = 0; i < 8; i++) begin
         rd("t6_rd", 6'(i), mk(32'h6000_0000 + 32'(i)));
         ts_seen[i] = rd_ts;
      end
      for (int i = 0; i < 7; i++) check("t6_ts_step", 160'(ts_seen[i + 1] - ts_seen[i]), 160'd1);
      rd("t6_oor", 6'd20, 160'd0);
      check("t6_ts_oor", 160'(rd_ts), 160'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
